// File: rtl/ppu_pkg.sv
// ppu_pkg: shared widths, sideband type and arithmetic helpers for the
// post-processing unit (ppu_vec / ppu_lane).
package ppu_pkg;

  localparam int DEF_LANES   = 4;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_MULT_W  = 16;
  localparam int DEF_SHIFT_W = 6;
  localparam int DEF_NUM_CH  = 64;
  localparam int DEF_CH_W    = $clog2(DEF_NUM_CH);

  // Per-beat control that travels alongside the data through the pipeline.
  typedef struct packed {
    logic                valid;
    logic                last;
    logic [DEF_CH_W-1:0] ch;
    logic                relu_en;
    logic                out_signed;
  } sb_t;

  // Rounding arithmetic right shift: adds half an LSB before shifting, so
  // ties round toward +inf. The 64-bit working width leaves headroom for
  // the rounding constant on top of the widest product.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] p,
                                                     input int unsigned       sh);
    logic signed [63:0] rnd;
    if (sh == 32'd0) begin
      return p;
    end else begin
      rnd = 64'sd1 <<< (sh - 32'd1);
      return (p + rnd) >>> sh;
    end
  endfunction

  // Clamp to the signed or unsigned range of an ow-bit result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] r,
                                                  input logic              sgn,
                                                  input int unsigned       ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (sgn) begin
      hi = (64'sd1 <<< (ow - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 32'd1));
    end else begin
      hi = (64'sd1 <<< ow) - 64'sd1;
      lo = 64'sd0;
    end
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/ppu_lane.sv
// ppu_lane: one lane of the post-processing datapath.
//   S1: p = acc * mult (signed x unsigned)
//   S2: optional ReLU, rounding right shift
//   S3: saturation to OUT_W, registered result
// Ports: clk, rst (async active-high), en (pipeline advance),
//   acc/mult (S1 inputs), relu/shift (controls of the beat in S1 register),
//   sgn (control of the beat in S2 register), out (S3 result).
module ppu_lane
  import ppu_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MULT_W  = DEF_MULT_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ACC_W-1:0]   acc,
  input  logic [MULT_W-1:0]  mult,
  input  logic               relu,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               sgn,
  output logic [OUT_W-1:0]   out
);

  localparam int P_W = ACC_W + MULT_W + 1;

  logic signed [P_W-1:0] acc_x;
  logic signed [P_W-1:0] mult_x;
  logic signed [P_W-1:0] p_r;
  logic signed [P_W-1:0] p_relu;
  logic signed [63:0]    p_wide;
  logic signed [63:0]    r_r;

  assign acc_x  = {{(P_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign mult_x = {{(P_W-MULT_W){1'b0}}, mult};

  // ReLU applied to the product: mult is non-negative, so clamping the
  // product is identical to clamping the accumulator before scaling.
  always_comb begin
    p_relu = (relu && p_r[P_W-1]) ? '0 : p_r;
    p_wide = {{(64-P_W){p_relu[P_W-1]}}, p_relu};
  end

  // Three datapath registers, all held while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r <= '0;
      r_r <= '0;
      out <= '0;
    end else if (en) begin
      p_r <= acc_x * mult_x;
      r_r <= round_shift(p_wide, int'(shift));
      out <= OUT_W'(saturate(r_r, sgn, OUT_W));
    end
  end

endmodule

// File: rtl/ppu_vec.sv
// ppu_vec: vectorised post-processing unit (ReLU, per-channel requantise,
// saturate) with a 3-stage pipeline and a single global stall.
// Ports: clk/rst (async active-high); cfg_we/cfg_addr/cfg_mult/cfg_shift
//   channel table write; ch_count/relu_en/out_signed per-beat controls;
//   in_valid/in_ready/in_data/in_last input stream; out_valid/out_ready/
//   out_data/out_last/out_ch output stream; busy = any stage occupied.
module ppu_vec
  import ppu_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int MULT_W  = DEF_MULT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic [MULT_W-1:0]      cfg_mult,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic [CH_W:0]          ch_count,
  input  logic                   relu_en,
  input  logic                   out_signed,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic [CH_W-1:0]        out_ch,
  output logic                   busy
);

  logic [MULT_W-1:0]  mult_tab [NUM_CH];
  logic [SHIFT_W-1:0] shift_tab[NUM_CH];

  logic               adv;
  logic [CH_W-1:0]    ch;
  logic [CH_W:0]      cc;
  logic               wrap;

  sb_t                s1_sb;
  logic [SHIFT_W-1:0] s1_shift;
  logic               s2_valid;
  logic               s2_last;
  logic [CH_W-1:0]    s2_ch;
  logic               s2_signed;

  // Bubbles are not squeezed: everything moves only when the output frees.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy     = s1_sb.valid || s2_valid || out_valid;

  // Effective channels per tile: 0 behaves as 1, oversize clamps to NUM_CH.
  always_comb begin
    if (ch_count == '0) begin
      cc = (CH_W+1)'(1);
    end else if (ch_count > (CH_W+1)'(NUM_CH)) begin
      cc = (CH_W+1)'(NUM_CH);
    end else begin
      cc = ch_count;
    end
    wrap = in_last || ({1'b0, ch} == (cc - (CH_W+1)'(1)));
  end

  // Channel table; a write lands at the edge, so a same-cycle S1 read sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mult_tab[i]  <= '0;
        shift_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      mult_tab[cfg_addr]  <= cfg_mult;
      shift_tab[cfg_addr] <= cfg_shift;
    end
  end

  // Channel counter and sideband pipeline, all on the global advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch        <= '0;
      s1_sb     <= '0;
      s1_shift  <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_ch     <= '0;
      s2_signed <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (adv) begin
      s1_sb     <= '{valid: in_valid, last: in_last, ch: ch,
                     relu_en: relu_en, out_signed: out_signed};
      s1_shift  <= shift_tab[ch];
      s2_valid  <= s1_sb.valid;
      s2_last   <= s1_sb.last;
      s2_ch     <= s1_sb.ch;
      s2_signed <= s1_sb.out_signed;
      out_valid <= s2_valid;
      out_last  <= s2_last;
      out_ch    <= s2_ch;
      if (in_valid) begin
        ch <= wrap ? '0 : ch + CH_W'(1);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ppu_lane #(
      .ACC_W  (ACC_W),
      .MULT_W (MULT_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .acc  (in_data[g*ACC_W +: ACC_W]),
      .mult (mult_tab[ch]),
      .relu (s1_sb.relu_en),
      .shift(s1_shift),
      .sgn  (s2_signed),
      .out  (out_data[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: doc/ppu_vec.md
# ppu_vec

Vectorised, parametrised post-processing unit between the PE-array accumulator drain and the activation SRAM writer. Per accepted beat it takes LANES signed accumulators of one output channel and applies optional ReLU, per-channel fixed-point requantisation (multiply, rounding right-shift) and saturation to signed or unsigned OUT_W. Per-channel scale/shift come from a small register file loaded before a tile. Full valid/ready handshake on both sides, 3-stage pipeline.

## Interface
- LANES, 4: elements per beat, all the same channel
- ACC_W, 32: accumulator width, signed two's complement
- OUT_W, 8: output element width
- MULT_W, 16: per-channel multiplier width, unsigned
- SHIFT_W, 6: per-channel right-shift width
- NUM_CH, 64: channel table depth; CH_W = $clog2(NUM_CH)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  CH_W  table entry
- cfg_mult  in  MULT_W  multiplier
- cfg_shift  in  SHIFT_W  shift amount
- ch_count  in  CH_W+1  channels per tile (1..NUM_CH), sampled per beat
- relu_en  in  1  clamp negatives to 0 before scaling
- out_signed  in  1  1: saturate to signed OUT_W; 0: to unsigned OUT_W
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  LANES*ACC_W  accumulators, lane 0 in LSBs
- in_last  in  1  last beat of tile
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  LANES*OUT_W  results, lane 0 in LSBs
- out_last  out  1  in_last delayed with its beat
- out_ch  out  CH_W  channel index of the output beat
- busy  out  1  any pipeline stage valid

## Operation
- Beat accepted when in_valid && in_ready. Channel counter ch (reset 0) tags beat; after acceptance ch <= (in_last || ch == ch_count-1) ? 0 : ch+1.
- S1: table read at ch; per lane x = (relu_en && acc<0) ? 0 : acc; p = x * mult (signed x unsigned, ACC_W+MULT_W+1 bits, no overflow possible).
- S2: if shift>0, r = (p + (1 << (shift-1))) >>> shift (round half up toward +inf); shift==0 gives r = p.
- S3: signed: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned: clamp to [0, 2^OUT_W-1]; result registered to out_data.
- Table: NUM_CH flops, reset to mult=0, shift=0. Write takes effect the next cycle; same-cycle write and S1 read of same entry returns old value. Writes while busy are legal and affect only beats entering S1 afterwards.
- relu_en, out_signed, ch_count sampled in S1 and carried with the beat; changing them mid-tile does not corrupt in-flight beats.

## Timing
- Latency: 3 cycles from accept to out_valid with out_ready held high; throughput 1 beat/cycle.
- Global stall: adv = !s3_valid || out_ready; all stages advance on adv; in_ready = adv. Bubbles are not squeezed.
- out_data/out_last/out_ch stable while out_valid && !out_ready.
- Reset (any time, asynchronous): all stage valids 0, out_valid 0, out_data 0, out_last 0, out_ch 0, busy 0, ch 0, table cleared; in-flight beats discarded. in_ready reads 1 during and after reset.
- ch_count = 0 treated as 1. Table index ≥ NUM_CH unreachable by construction when ch_count ≤ NUM_CH; ch_count > NUM_CH clamps to NUM_CH.

## Structure
- Package ppu_pkg: default width localparams, round_shift and saturate functions, a stage-sideband struct (valid, last, ch, relu_en, out_signed).
- Sub-module ppu_lane: one lane's S1–S3 datapath with stall enable, instantiated LANES times; ppu_vec holds table, channel counter, sideband pipeline and handshake.

## Test plan
- relu_en=1, out_signed=1, ch0 mult=1 shift=0; lanes {-5, 0, 100, 300} -> out {0, 0, 100, 127} after exactly 3 cycles.
- relu_en=0, mult=3 shift=2; lanes {10, -10, -2, 1} -> {8, -7, -1, 1}; out_signed=0 with acc=-10 -> 0, acc=400 mult=1 -> 255.
- ch_count=3, table ch0/1/2 mults 1/2/4 shift 0, 7 beats of acc=1, in_last on beat 4 -> out_ch 0,1,2,0,0,1,2, data 1,2,4,1,1,2,4, out_last on 4th output only.
- Continuous input, out_ready low for 5 cycles -> in_ready low after 3 beats fill; after release every beat out once, in order, nothing dropped or duplicated.
- rst pulsed with 2 beats in flight -> out_valid 0 immediately, those beats never appear; next beat tagged ch 0 with mult=0 -> output 0.
- cfg write ch0 mult=5 in same cycle a ch0 beat enters S1 -> that beat uses old mult; next ch0 beat uses 5.
